navre_simctl: RTL

- Synthesizable simulation/board-test controller on the navre I/O bus.
- Generalises the bench-side I/O responder into one reusable block:
  - end-of-test and exit-code register with pass/fail decode
  - console byte FIFO
  - snapshot cycle counter
  - watchdog timeout
  - N memory-mapped general-purpose input bytes
- Sits beside softusb_navre. Its outputs are watched by testbenches or routed to board LEDs/UART.

---
 rtl/navre_simctl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/navre_simctl.sv
// navre_simctl: simulation / board-test controller on the navre I/O bus.
//
// Register window at io_base (offsets):
//   0 EXIT     W: latch exit code and set end_of_test (first write wins)  R: exit_code
//   1 CONSOLE  W: push byte into console FIFO  R: {5'b0, overflow, full, empty}
//   2/3/4      R: cycle count byte 0 (snapshots bytes 1/2), snapshot byte 1, snapshot byte 2
//   5 WDT      W: clear watchdog counter  R: {7'b0, timeout}
//   6+k        R: general-purpose input byte k
//
// Ports:
//   sys_clk, sys_rst         clock, asynchronous active-high reset
//   io_re, io_we, io_a,      CPU I/O bus strobes, address, write data
//   io_di, io_do             registered read data (valid the cycle after io_re)
//   gpi                      n_inputs general-purpose input bytes
//   end_of_test, test_pass,  sticky done flag, pass decode (exit_code == FE),
//   exit_code, timeout       latched exit value, sticky watchdog flag
//   con_valid, con_data,     console FIFO head (valid/data) and consumer pop
//   con_ready
module navre_simctl #(
   parameter logic [5:0]  io_base   = 6'h00,
   parameter int unsigned n_inputs  = 2,
   parameter int unsigned fifo_aw   = 4,
   parameter int unsigned wdt_width = 20
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  io_re,
   input  logic                  io_we,
   input  logic [5:0]            io_a,
   input  logic [7:0]            io_di,
   output logic [7:0]            io_do,
   input  logic [8*n_inputs-1:0] gpi,
   output logic                  end_of_test,
   output logic                  test_pass,
   output logic [7:0]            exit_code,
   output logic                  timeout,
   output logic                  con_valid,
   output logic [7:0]            con_data,
   input  logic                  con_ready
);

   localparam int unsigned Depth    = 1 << fifo_aw;
   localparam logic [5:0]  last_off = 6'(5 + n_inputs);

   // Address decode
   logic [5:0] off;
   logic       hit, rd, wr_exit, wr_con, kick, rd_status, rd_cyc_lo;

   assign off       = io_a - io_base;
   assign hit       = (off <= last_off);
   assign rd        = io_re & hit;
   assign wr_exit   = io_we & hit & (off == 6'd0);
   assign wr_con    = io_we & hit & (off == 6'd1);
   assign kick      = io_we & hit & (off == 6'd5);
   assign rd_status = rd & (off == 6'd1);
   assign rd_cyc_lo = rd & (off == 6'd2);

   // Console FIFO
   logic [7:0]         mem [Depth];
   logic [fifo_aw-1:0] wptr_q, rptr_q;
   logic [fifo_aw:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               full, empty, pop, push_ok;

   assign full      = (count_q == (fifo_aw+1)'(Depth));
   assign empty     = (count_q == '0);
   assign con_valid = !empty;
   assign con_data  = mem[rptr_q];
   assign pop       = con_valid & con_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok   = wr_con & (!full | pop);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (!push_ok && pop) count_d = count_q - 1'b1;
      // A dropped byte outranks a same-cycle status read clearing the flag.
      overflow_d = overflow_q;
      if (wr_con && !push_ok) overflow_d = 1'b1;
      else if (rd_status)     overflow_d = 1'b0;
   end

   always_ff @(posedge sys_clk) begin
      if (push_ok) mem[wptr_q] <= io_di;
   end

   // Exit code and watchdog
   logic [wdt_width-1:0] wdt_q, wdt_d;
   logic                 eot_d, timeout_d, pass_d;
   logic [7:0]           exit_d;

   always_comb begin
      eot_d     = end_of_test;
      exit_d    = exit_code;
      timeout_d = timeout;
      wdt_d     = wdt_q;
      if (kick) begin
         wdt_d = '0;
      end else if (!end_of_test) begin
         if (wdt_q == '1) begin
            timeout_d = 1'b1;
            eot_d     = 1'b1;
            exit_d    = 8'hEE;
         end else begin
            wdt_d = wdt_q + 1'b1;
         end
      end
      // A CPU exit write on the terminal-count cycle takes precedence over the timeout.
      if (wr_exit && !end_of_test) begin
         eot_d     = 1'b1;
         exit_d    = io_di;
         timeout_d = 1'b0;
      end
      pass_d = eot_d & (exit_d == 8'hFE);
   end

   // Cycle counter and read mux
   logic [23:0] cyc_q;
   logic [15:0] snap_q;
   logic [7:0]  rd_data;

   always_comb begin
      rd_data = 8'h00;
      case (off)
         6'd0:    rd_data = exit_code;
         6'd1:    rd_data = {5'b0, overflow_q, full, empty};
         6'd2:    rd_data = cyc_q[7:0];
         6'd3:    rd_data = snap_q[7:0];
         6'd4:    rd_data = snap_q[15:8];
         6'd5:    rd_data = {7'b0, timeout};
         default: begin
            for (int k = 0; k < n_inputs; k++) begin
               if (off == 6'(6 + k)) rd_data = gpi[8*k +: 8];
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         io_do       <= 8'h00;
         end_of_test <= 1'b0;
         test_pass   <= 1'b0;
         exit_code   <= 8'h00;
         timeout     <= 1'b0;
         wdt_q       <= '0;
         cyc_q       <= '0;
         snap_q      <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (rd)        io_do  <= rd_data;
         if (rd_cyc_lo) snap_q <= cyc_q[23:8];
         end_of_test <= eot_d;
         test_pass   <= pass_d;
         exit_code   <= exit_d;
         timeout     <= timeout_d;
         wdt_q       <= wdt_d;
         cyc_q       <= cyc_q + 24'd1;
         if (push_ok) wptr_q <= wptr_q + fifo_aw'(1);
         if (pop)     rptr_q <= rptr_q + fifo_aw'(1);
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

endmodule
